// File: rtl/assist_mode_indicator_if.sv
// Assist-setting / brightness inputs and LED bar outputs of the assist-mode indicator.
interface assist_mode_indicator_if #(
  parameter int unsigned PWM_BITS = 4
);
  logic [1:0]          setting;
  logic [PWM_BITS-1:0] duty;
  logic [3:0]          led;
  logic                busy;

  modport master (output setting, output duty, input led, input busy);
  modport slave  (input setting, input duty, output led, output busy);
endinterface

// File: rtl/assist_mode_indicator.sv
// Drives a 4-LED bar from the assist setting: a PWM-dimmed bar at rest, and
// setting+1 full-brightness confirmation flashes after every setting change.
module assist_mode_indicator #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned BLINK_MS = 250,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  assist_mode_indicator_if.slave  bus
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned TW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;

  logic [1:0]          state, state_d;
  logic [1:0]          setting_q;
  logic [1:0]          flash_left, flash_d;
  logic [PW-1:0]       presc, presc_d;
  logic [TW-1:0]       tcnt, tcnt_d;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_d;
  logic [3:0]          led_d;
  logic                busy_d;
  logic                chg_c;
  logic                tick_c;
  logic                phase_end_c;
  logic                lit_c;

  function automatic logic [3:0] bar(input logic [1:0] s);
    case (s)
      2'd0:    bar = 4'b0001;
      2'd1:    bar = 4'b0011;
      2'd2:    bar = 4'b0111;
      default: bar = 4'b1111;
    endcase
  endfunction

  assign chg_c       = (bus.setting != setting_q);
  assign tick_c      = (presc == PW'(CLK_DIV - 1));
  assign phase_end_c = tick_c && (tcnt == TW'(BLINK_MS - 1));

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      setting_q  <= 2'b10;
      flash_left <= 2'd0;
      presc      <= '0;
      tcnt       <= '0;
      pwm_cnt    <= '0;
      bus.led    <= 4'b0000;
      bus.busy   <= 1'b0;
    end else begin
      state      <= state_d;
      setting_q  <= bus.setting;
      flash_left <= flash_d;
      presc      <= presc_d;
      tcnt       <= tcnt_d;
      pwm_cnt    <= pwm_d;
      bus.led    <= led_d;
      bus.busy   <= busy_d;
    end
  end

  // Next-state, counters and output decode; a setting change pre-empts everything
  always_comb begin
    state_d = state;
    flash_d = flash_left;
    presc_d = presc;
    tcnt_d  = tcnt;
    pwm_d   = pwm_cnt + PWM_BITS'(1);
    lit_c   = 1'b0;
    led_d   = 4'b0000;
    busy_d  = 1'b0;

    if (chg_c) begin
      state_d = ON;
      flash_d = bus.setting;
      presc_d = '0;
      tcnt_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          presc_d = '0;
          tcnt_d  = '0;
        end
        ON, OFF: begin
          presc_d = tick_c ? '0 : presc + PW'(1);
          if (tick_c) begin
            tcnt_d = phase_end_c ? '0 : tcnt + TW'(1);
          end
          if (phase_end_c) begin
            if (state == ON) begin
              state_d = OFF;
            end else if (flash_left == 2'd0) begin
              state_d = IDLE;
            end else begin
              flash_d = flash_left - 2'd1;
              state_d = ON;
            end
          end
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
          tcnt_d  = '0;
        end
      endcase
    end

    // setting_q's next value is always the current setting input
    lit_c = (pwm_d < bus.duty);
    case (state_d)
      ON:      led_d = bar(bus.setting);
      OFF:     led_d = 4'b0000;
      default: led_d = bar(bus.setting) & {4{lit_c}};
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_assist_mode_indicator.sv
// Randomized and scenario-driven scoreboard bench for assist_mode_indicator.
module tb_assist_mode_indicator;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned BLINK_MS = 3;
  localparam int unsigned PWM_BITS = 4;
  localparam int unsigned PH       = CLK_DIV * BLINK_MS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  assist_mode_indicator_if #(.PWM_BITS(PWM_BITS)) bus ();

  assist_mode_indicator #(
    .CLK_DIV (CLK_DIV),
    .BLINK_MS(BLINK_MS),
    .PWM_BITS(PWM_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] led;
    logic       busy;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: elapsed time since the last setting change decides everything
  int   m_pwm    = 0;
  int   m_sq     = 2;
  bit   m_in_seq = 0;
  int   m_k      = 0;
  int   m_s      = 0;

  function automatic logic [3:0] bar_ref(input int s);
    logic [3:0] full;
    full = 4'b1111;
    return full >> (3 - s);
  endfunction

  task automatic step(input logic r, input logic [1:0] s, input logic [3:0] d);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.setting = s;
    bus.duty    = d;
    cyc++;
    if (r) begin
      m_pwm = 0;
      m_sq = 2;
      m_in_seq = 0;
      e.led = 4'b0000;
      e.busy = 1'b0;
    end else begin
      m_pwm = (m_pwm + 1) % (1 << PWM_BITS);
      if (int'(s) != m_sq) begin
        m_in_seq = 1;
        m_k = 0;
        m_s = int'(s);
      end else if (m_in_seq) begin
        m_k++;
        if (m_k >= 2 * (m_s + 1) * int'(PH)) m_in_seq = 0;
      end
      m_sq = int'(s);
      if (m_in_seq) begin
        e.led  = ((m_k / int'(PH)) % 2 == 0) ? bar_ref(m_s) : 4'b0000;
        e.busy = 1'b1;
      end else begin
        e.led  = (m_pwm < int'(d)) ? bar_ref(m_sq) : 4'b0000;
        e.busy = 1'b0;
      end
    end
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic [1:0] s, input logic [3:0] d);
    for (int i = 0; i < n; i++) step(1'b0, s, d);
  endtask

  // Monitor: outputs update every cycle, so compare once per clock after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.led !== e.led || bus.busy !== e.busy) begin
          n_fail++;
          $display("FAIL cyc%0d led/busy: got %b/%b expected %b/%b",
                   e.cyc, bus.led, bus.busy, e.led, e.busy);
        end
      end
    end
  end

  initial begin
    logic [1:0] s;
    logic [3:0] d;
    int         waited;
    bus.setting = 2'd2;
    bus.duty    = 4'd15;

    // Reset, then steady bar at duty 15 (dark only when pwm_cnt is 15)
    for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 4'd15);
    hold(40, 2'd2, 4'd15);
    // 2->3: four flashes, 96 busy cycles, then steady full bar
    hold(110, 2'd3, 4'd15);
    // 3->0 wrap: a single flash
    hold(30, 2'd0, 4'd15);
    // 0->1 then 1->2 mid-sequence: restart with three flashes
    hold(30, 2'd1, 4'd15);
    hold(80, 2'd2, 4'd15);
    // duty 0: dark at rest, flashes still full brightness
    hold(20, 2'd2, 4'd0);
    hold(60, 2'd3, 4'd0);
    // Reset during an OFF phase, setting held at 2 afterwards
    hold(18, 2'd0, 4'd7);
    step(1'b1, 2'd2, 4'd7);
    hold(30, 2'd2, 4'd7);

    // Randomized phase
    s = 2'd2;
    d = 4'd9;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) begin
        step(1'b1, s, d);
      end else begin
        step(1'b0, s, d);
      end
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
